// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl: slews a 9-bit angle command toward an accepted target by at most STEP per frame.
// Define SERVO_RAMP_LIMIT_EN to clamp targets to [MIN_ANGLE, MAX_ANGLE] and report it on limit_hit.
module servo_ramp_ctrl #(
   parameter int FRAME_CYCLES = 2000000,
   parameter int STEP = 2,
   parameter int INIT_ANGLE = 90,
   parameter int MIN_ANGLE = 0,
   parameter int MAX_ANGLE = 180
) (
   input  logic clk,
   input  logic clr,
   input  logic [8:0] tgt_angle,
   input  logic tgt_valid,
   output logic tgt_ready,
   output logic [31:0] command,
   output logic busy,
   output logic done,
   output logic limit_hit
);
   localparam int CW = $clog2(FRAME_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);
   localparam logic [8:0] STP = 9'(STEP);
   localparam logic [8:0] INIT = 9'(INIT_ANGLE);
   typedef enum logic {IDLE, RAMP} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [8:0] angle, angle_n, target, target_n, clamped, diff, stepped;
   logic tick, accept, done_n, limit_n;
   assign tick = cnt == LAST;
   assign accept = tgt_valid && tgt_ready;
   assign busy = state == RAMP;
   assign command = {23'd0, angle};
`ifdef SERVO_RAMP_LIMIT_EN
   localparam logic [8:0] LO = 9'(MIN_ANGLE);
   localparam logic [8:0] HI = 9'(MAX_ANGLE);
   assign clamped = tgt_angle < LO ? LO : tgt_angle > HI ? HI : tgt_angle;
   assign limit_n = accept && clamped != tgt_angle;
`else
   logic unused_cfg;
   assign unused_cfg = MIN_ANGLE > MAX_ANGLE;
   assign clamped = tgt_angle > 9'd180 ? 9'd180 : tgt_angle;
   assign limit_n = 1'b0;
`endif
   // The step uses the pre-accept target; a target accepted on the same edge steers later ticks.
   always_comb begin
      diff = target >= angle ? target - angle : angle - target;
      stepped = diff <= STP ? target : target > angle ? angle + STP : angle - STP;
      angle_n = state == RAMP && tick ? stepped : angle;
      target_n = accept ? clamped : target;
      state_n = state;
      done_n = 1'b0;
      if (accept || state == RAMP) begin
         state_n = angle_n == target_n ? IDLE : RAMP;
         done_n = angle_n == target_n;
      end
   end
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
         cnt <= '0;
         angle <= INIT;
         target <= INIT;
         tgt_ready <= 1'b0;
         done <= 1'b0;
         limit_hit <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= tick ? '0 : cnt + CW'(1);
         angle <= angle_n;
         target <= target_n;
         tgt_ready <= 1'b1;
         done <= done_n;
         limit_hit <= limit_n;
      end
   end
endmodule

// File: doc/servo_ramp_ctrl.md
Name: servo_ramp_ctrl

Overview:
- Upstream command generator for the servo PWM interface: accepts target angles over a valid/ready handshake and drives the 32-bit `command` bus the PWM interface consumes.
- Slews `command` toward the target by at most STEP degrees per 20 ms servo frame, so the servo never jumps abruptly.
- Sits between the processor/AXI register slice and the PWM interface.

Parameters:
- FRAME_CYCLES, 2000000, clk cycles per ramp update (20 ms at 100 MHz); minimum 2.
- STEP, 2, maximum angle change in degrees per frame; range 1..180.
- INIT_ANGLE, 90, angle loaded at reset.
- MIN_ANGLE, 0, lower clamp, used only with the optional feature.
- MAX_ANGLE, 180, upper clamp, used only with the optional feature.

Ports:
- clk  in  1  system clock.
- clr  in  1  reset; asynchronous, active-low (0 = reset).
- tgt_angle  in  9  requested angle in degrees, 0..511 encodable.
- tgt_valid  in  1  tgt_angle is valid this cycle.
- tgt_ready  out  1  block accepts a target this cycle.
- command  out  32  to the PWM interface; bits [8:0] = current angle, bits [31:9] = 0.
- busy  out  1  high while current angle differs from target.
- done  out  1  one-cycle pulse when current angle reaches target.
- limit_hit  out  1  one-cycle pulse when an accepted target was clamped.

Behaviour:
- Reset (clr=0, async) values:
  - command = INIT_ANGLE; internal target = INIT_ANGLE.
  - Frame counter = 0.
  - State = IDLE.
  - busy = 0, done = 0, limit_hit = 0, tgt_ready = 0.
- tgt_ready goes 1 on the first clk edge after clr deasserts and stays 1; retargeting mid-ramp is allowed.
- Accept occurs when tgt_valid && tgt_ready at a rising edge. The clamped value is latched into target that edge. Sanitisation without the feature: values >180 saturate to 180.
- Frame counter:
  - Free-runs 0..FRAME_CYCLES-1, then wraps to 0.
  - tick = (count == FRAME_CYCLES-1); a tick occurs every FRAME_CYCLES cycles.
  - Not phase-aligned to the PWM counter. A change to `command` mid-PWM-period is acceptable because the PWM comparator samples continuously.
- States:
  - IDLE: command == target, busy = 0. An accept with new target != command goes to RAMP next cycle (busy = 1). An accept with target == command stays in IDLE and pulses done the next cycle.
  - RAMP: on tick, let diff = |target − command|:
    - if diff <= STEP: command = target, state goes to IDLE, done = 1 for one cycle, busy = 0 the same cycle.
    - otherwise command moves toward target by exactly STEP.
    - Direction is evaluated every tick from the current target.
- Simultaneous accept and tick in RAMP: the tick step uses the old target; the new target is latched the same edge and is used from the next tick.
- Latency: the first movement occurs at the first tick after the accept edge, which is 1..FRAME_CYCLES cycles later.
- Total ramp time: ceil(diff/STEP) ticks.
- Arithmetic: 9-bit unsigned compare and subtract; a step never overshoots and never wraps below 0.
- command changes only on a tick edge, or on reset.
- clr asserted mid-ramp: immediate async return to reset values; any pending done pulse is discarded.

Optional Feature:
- Macro: SERVO_RAMP_LIMIT_EN.
- Defined:
  - Accepted targets are clamped to [MIN_ANGLE, MAX_ANGLE].
  - limit_hit pulses for one cycle after the accept edge whenever clamping changed the value.
  - INIT_ANGLE must lie within the range; the bench checks this.
- Undefined:
  - Only the >180 saturation applies.
  - limit_hit is tied to 0.
  - MIN_ANGLE and MAX_ANGLE are ignored.

Test Plan (FRAME_CYCLES=10, STEP=2, INIT_ANGLE=90):
1. Reset hold, then release: command=90, busy=0, done=0 and tgt_ready=0 during reset; tgt_ready=1 one cycle after release; command unchanged for 50 cycles.
2. Accept target 96: busy=1; command goes 92, 94, 96 on three successive ticks, 10 cycles apart; done pulses exactly once with command=96; busy=0 thereafter.
3. Accept target 85 from 90: command goes 88, 86, 85 (final partial step of 1); no overshoot; done pulses once.
4. Mid-ramp retarget: ramp 90→120; after command=94, accept 80; next ticks give 92, 90, … and end at 80; done pulses only at 80; retarget on a tick edge applies the old-direction step first.
5. Accept 300 with the macro undefined: target saturates to 180 and the ramp ends at 180, limit_hit=0. With the macro defined and MIN/MAX=20/160: accept 300 gives a limit_hit pulse and ends at 160; accept 5 ends at 20.
6. Assert clr mid-ramp at command=100: command=90, busy=0 asynchronously before the next edge; no done pulse; accept target 90 after release produces a done pulse the next cycle with no movement.
